wb_queue: RTL and testbench



---
 rtl/wb_queue_pkg.sv | 12 +
 rtl/wb_lookup.sv | 34 +++
 rtl/wb_queue.sv | 93 +++++++++
 tb/tb_wb_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared defaults, entry layout and pointer width for the writeback queue
package wb_queue_pkg;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_DEPTH      = 4;
  localparam int WB_PTR_W      = $clog2(WB_DEPTH);
  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_lookup.sv
// wb_lookup: newest-first match of one operand address against the pending queue entries
module wb_lookup
  import wb_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = WB_DEPTH,
  parameter int PW         = $clog2(DEPTH),
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic [DEPTH-1:0]      vld_i,
  input  logic [ADDR_WIDTH-1:0] rd_i   [DEPTH],
  input  logic [DATA_WIDTH-1:0] data_i [DEPTH],
  input  logic [PW-1:0]         head_i,
  input  logic [CW-1:0]         count_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [PW-1:0] idx;
  // Walk oldest to newest so a later match overrides an earlier one; x0 never hits
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (CW'(k) < count_i && vld_i[idx] && rd_i[idx] == addr_i && addr_i != '0) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: writeback FIFO draining into the register-file write port, with operand forwarding; WB_QUEUE_BYPASS_EN enables zero-latency bypass when empty
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [ADDR_WIDTH-1:0]      enq_rd,
  input  logic [DATA_WIDTH-1:0]      enq_data,
  input  logic                       flush,
  input  logic                       rf_busy,
  output logic                       rf_we,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  input  logic [ADDR_WIDTH-1:0]      lk_addr1,
  input  logic [ADDR_WIDTH-1:0]      lk_addr2,
  output logic                       lk_hit1,
  output logic                       lk_hit2,
  output logic [DATA_WIDTH-1:0]      lk_data1,
  output logic [DATA_WIDTH-1:0]      lk_data2,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic                  empty, byp, push, pop, q_hit1, q_hit2;
  logic [DATA_WIDTH-1:0] q_data1, q_data2;
  assign empty     = count_q == '0;
  assign enq_ready = count_q < CW'(DEPTH);
  assign count     = count_q;
`ifdef WB_QUEUE_BYPASS_EN
  assign byp = enq_valid && empty && !rf_busy && !flush && enq_rd != '0;
`else
  assign byp = 1'b0;
`endif
  assign pop      = !empty && !rf_busy;
  assign push     = enq_valid && enq_ready && enq_rd != '0 && !byp && !flush;
  assign rf_we    = byp || pop;
  assign rf_waddr = byp ? enq_rd : empty ? '0 : rd_q[head_q];
  assign rf_wdata = byp ? enq_data : empty ? '0 : data_q[head_q];
  assign lk_hit1  = q_hit1 || (byp && lk_addr1 == enq_rd);
  assign lk_hit2  = q_hit2 || (byp && lk_addr2 == enq_rd);
  assign lk_data1 = (byp && lk_addr1 == enq_rd) ? enq_data : q_data1;
  assign lk_data2 = (byp && lk_addr2 == enq_rd) ? enq_data : q_data2;
  // Next pointers, occupancy and valid bits; flush wins over push and pop
  always_comb begin
    vld_d = vld_q;
    if (pop) vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
    head_d  = flush ? '0 : head_q + PW'(pop);
    tail_d  = flush ? '0 : tail_q + PW'(push);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    vld_d   = flush ? '0 : vld_d;
  end
  // Queue control state with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end
  // Entry payload storage; only guarded by the valid bits, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= enq_rd;
      data_q[tail_q] <= enq_data;
    end
  end
  wb_lookup #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lk1 (
    .vld_i(vld_q), .rd_i(rd_q), .data_i(data_q), .head_i(head_q), .count_i(count_q),
    .addr_i(lk_addr1), .hit_o(q_hit1), .data_o(q_data1)
  );
  wb_lookup #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lk2 (
    .vld_i(vld_q), .rd_i(rd_q), .data_i(data_q), .head_i(head_q), .count_i(count_q),
    .addr_i(lk_addr2), .hit_o(q_hit2), .data_o(q_data2)
  );
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed self-checking bench for wb_queue
module tb_wb_queue;
  logic        clk, reset_n, enq_valid, enq_ready, flush, rf_busy, rf_we;
  logic        lk_hit1, lk_hit2;
  logic [4:0]  enq_rd, rf_waddr, lk_addr1, lk_addr2;
  logic [31:0] enq_data, rf_wdata, lk_data1, lk_data2;
  logic [2:0]  count;
  int checks = 0;
  int errors = 0;
  wb_queue dut (
    .clk(clk), .reset_n(reset_n), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_rd(enq_rd), .enq_data(enq_data), .flush(flush), .rf_busy(rf_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lk_addr1(lk_addr1), .lk_addr2(lk_addr2), .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
    .lk_data1(lk_data1), .lk_data2(lk_data2), .count(count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic enq(input logic [4:0] rd, input logic [31:0] d);
    enq_valid = 1'b1;
    enq_rd    = rd;
    enq_data  = d;
    @(negedge clk);
    enq_valid = 1'b0;
    #1;
  endtask
  initial begin
    reset_n = 1'b0; enq_valid = 1'b0; enq_rd = '0; enq_data = '0;
    flush = 1'b0; rf_busy = 1'b0; lk_addr1 = '0; lk_addr2 = '0;
    #3;
    chk("rst_we", rf_we, 0);
    chk("rst_ready", enq_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_hit1", lk_hit1, 0);
    chk("rst_data1", lk_data1, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // single entry, 1-cycle latency (or same-cycle with bypass)
    enq_valid = 1'b1; enq_rd = 5'd5; enq_data = 32'hDEADBEEF;
    #1;
`ifdef WB_QUEUE_BYPASS_EN
    chk("byp5_we", rf_we, 1);
    chk("byp5_waddr", rf_waddr, 5);
    @(negedge clk);
    enq_valid = 1'b0;
    #1;
    chk("byp5_we_after", rf_we, 0);
`else
    chk("q5_we_early", rf_we, 0);
    @(negedge clk);
    enq_valid = 1'b0;
    #1;
    chk("q5_we", rf_we, 1);
    chk("q5_waddr", rf_waddr, 5);
    chk("q5_wdata", rf_wdata, 32'hDEADBEEF);
    chk("q5_count", count, 1);
    @(negedge clk);
    #1;
`endif
    chk("q5_count_after", count, 0);
    chk("q5_we_after", rf_we, 0);
    // fill to full while the port is busy, then drain in order
    rf_busy = 1'b1;
    for (int i = 1; i <= 4; i++) enq(5'(i), 32'h100 + i);
    chk("full_count", count, 4);
    chk("full_ready", enq_ready, 0);
    chk("full_we", rf_we, 0);
    lk_addr1 = 5'd3;
    #1;
    chk("full_hit3", lk_hit1, 1);
    chk("full_data3", lk_data1, 32'h103);
    rf_busy = 1'b0;
    #1;
    chk("full_pop_ready", enq_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_we", rf_we, 1);
      chk("drain_waddr", rf_waddr, i);
      chk("drain_wdata", rf_wdata, 32'h100 + i);
      @(negedge clk);
      #1;
      if (i == 1) chk("drain_ready", enq_ready, 1);
    end
    chk("drain_done_we", rf_we, 0);
    chk("drain_done_count", count, 0);
    // two writes to the same register: newest forwards, oldest drains first
    rf_busy = 1'b1;
    enq(5'd7, 32'h11);
    enq(5'd7, 32'h22);
    lk_addr1 = 5'd7;
    lk_addr2 = 5'd7;
    #1;
    chk("dup_hit1", lk_hit1, 1);
    chk("dup_data1", lk_data1, 32'h22);
    chk("dup_data2", lk_data2, 32'h22);
    rf_busy = 1'b0;
    #1;
    chk("dup_w1", rf_wdata, 32'h11);
    chk("dup_w1_lk", lk_data1, 32'h22);
    @(negedge clk);
    #1;
    chk("dup_w2", rf_wdata, 32'h22);
    chk("dup_w2_hit", lk_hit1, 1);
    @(negedge clk);
    #1;
    chk("dup_end_hit", lk_hit1, 0);
    chk("dup_end_data", lk_data1, 0);
    // x0 is accepted but dropped
    enq_valid = 1'b1; enq_rd = 5'd0; enq_data = 32'hFFFF;
    #1;
    chk("x0_ready", enq_ready, 1);
    chk("x0_we_now", rf_we, 0);
    @(negedge clk);
    enq_valid = 1'b0;
    lk_addr2 = 5'd0;
    #1;
    chk("x0_count", count, 0);
    chk("x0_we", rf_we, 0);
    chk("x0_hit2", lk_hit2, 0);
    // enqueue and pop on the same edge
    rf_busy = 1'b1;
    enq(5'd8, 32'h88);
    rf_busy = 1'b0;
    enq_valid = 1'b1; enq_rd = 5'd9; enq_data = 32'h99;
    #1;
    chk("sim_waddr8", rf_waddr, 8);
    @(negedge clk);
    enq_valid = 1'b0;
    #1;
    chk("sim_count", count, 1);
    chk("sim_waddr9", rf_waddr, 9);
    @(negedge clk);
    #1;
    chk("sim_empty", count, 0);
    // flush beats enqueue; the in-flight head write still goes out
    rf_busy = 1'b1;
    for (int i = 10; i <= 12; i++) enq(5'(i), 32'hA0 + i);
    chk("fl_count3", count, 3);
    rf_busy = 1'b0; flush = 1'b1;
    enq_valid = 1'b1; enq_rd = 5'd13; enq_data = 32'hD;
    #1;
    chk("fl_we", rf_we, 1);
    chk("fl_waddr", rf_waddr, 10);
    @(negedge clk);
    flush = 1'b0; enq_valid = 1'b0; lk_addr1 = 5'd13;
    #1;
    chk("fl_count", count, 0);
    chk("fl_we_after", rf_we, 0);
    chk("fl_hit13", lk_hit1, 0);
    // asynchronous reset mid-drain
    rf_busy = 1'b1;
    enq(5'd20, 32'h20);
    enq(5'd21, 32'h21);
    rf_busy = 1'b0;
    #1;
    chk("ar_we_before", rf_we, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_we", rf_we, 0);
    chk("ar_count", count, 0);
    chk("ar_ready", enq_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_count_after", count, 0);
    chk("ar_we_after", rf_we, 0);
    // empty queue, port free: bypass or queued path depending on build
    lk_addr1 = 5'd9;
    enq_valid = 1'b1; enq_rd = 5'd9; enq_data = 32'hABCD;
    #1;
`ifdef WB_QUEUE_BYPASS_EN
    chk("bp_we", rf_we, 1);
    chk("bp_waddr", rf_waddr, 9);
    chk("bp_wdata", rf_wdata, 32'hABCD);
    chk("bp_hit", lk_hit1, 1);
    chk("bp_lkdata", lk_data1, 32'hABCD);
    @(negedge clk);
    enq_valid = 1'b0;
    #1;
    chk("bp_count", count, 0);
`else
    chk("nb_we", rf_we, 0);
    chk("nb_hit", lk_hit1, 0);
    @(negedge clk);
    enq_valid = 1'b0;
    #1;
    chk("nb_we_next", rf_we, 1);
    chk("nb_waddr", rf_waddr, 9);
    chk("nb_hit_next", lk_hit1, 1);
    chk("nb_count", count, 1);
`endif
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
